// File: rtl/lamp_bus_pkg.sv
// Shared definitions for the lamp bus card responder: bus widths,
// register count default, FSM state encoding and synchronizer idle levels.
package lamp_bus_pkg;

    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 3;
    localparam int BID_W        = 4;
    localparam int NUM_REGS_DEF = 8;

    // Synchronized bundle layout: {data, addr, b_id, rd_n, wr_n, lamp_reset}
    localparam int SYNC_W = DATA_W + ADDR_W + BID_W + 3;

    // Idle bus levels: strobes inactive (high), everything else low
    localparam logic [SYNC_W-1:0] SYNC_IDLE = {{(SYNC_W - 3){1'b0}}, 3'b110};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LOW,
        ST_WR_COMMIT,
        ST_RD_DRIVE,
        ST_COLLIDE
    } state_e;

endpackage

// File: rtl/bus_sync.sv
// Two-flop synchronizer for a bundle of asynchronous bus pins, with a
// configurable reset value so each bit comes out of reset at its idle level.
module bus_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Shift the raw pins through two flops before anyone looks at them
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep both flop stages updating from
        // pre-edge values, so the chain really is two cycles deep.
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/lamp_card_responder.sv
// Lamp card bus responder: synchronizes the slow parallel bus, qualifies
// write strobes by minimum low time, commits writes into the lamp register
// file and drives read data while a selected read strobe is held.
module lamp_card_responder
    import lamp_bus_pkg::*;
#(
    parameter int CARD_INDEX        = 0,
    parameter int MIN_STROBE_CYCLES = 8,
    parameter int NUM_REGS          = NUM_REGS_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_oe,
    input  logic [ADDR_W-1:0]          addr_pins,
    input  logic [BID_W-1:0]           b_id_pins,
    input  logic                       rd_n,
    input  logic                       wr_n,
    input  logic                       lamp_reset,
    output logic                       reg_write_valid,
    output logic [ADDR_W-1:0]          reg_write_addr,
    output logic [DATA_W-1:0]          reg_write_data,
    output logic [DATA_W*NUM_REGS-1:0] lamp_state,
    output logic                       strobe_error
);

    localparam int               CNT_W   = $clog2(MIN_STROBE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_STROBE_CYCLES);

    logic [SYNC_W-1:0] sync_bus;
    logic [DATA_W-1:0] data_s;
    logic [ADDR_W-1:0] addr_s;
    logic [BID_W-1:0]  bid_s;
    logic              rd_s, wr_s, lr_s;

    bus_sync #(
        .WIDTH     (SYNC_W),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   ({data_in, addr_pins, b_id_pins, rd_n, wr_n, lamp_reset}),
        .q_o   (sync_bus)
    );

    assign {data_s, addr_s, bid_s, rd_s, wr_s, lr_s} = sync_bus;

    // Only our own board-ID bit matters; the rest are deliberately ignored
    logic unused_bid;
    assign unused_bid = ^bid_s;

    logic selected, collide;
    assign selected = bid_s[CARD_INDEX];
    assign collide  = !rd_s && !wr_s;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] rd_val;
    logic              wr_hit;
    logic              commit;

    // Decode read data for the live address and range-check the latched write address
    always_comb begin
        rd_val = '0;
        wr_hit = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_s == ADDR_W'(k)) rd_val = regs_q[k];
            if (addr_q == ADDR_W'(k)) wr_hit = 1'b1;
        end
    end

    // Next-state logic for the bus protocol FSM
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (selected && collide) begin
                    state_d = ST_COLLIDE;
                    err_d   = 1'b1;
                end else if (selected && !wr_s) begin
                    state_d = ST_WR_LOW;
                    addr_d  = addr_s;
                    cnt_d   = '0;
                end else if (selected && !rd_s) begin
                    state_d = ST_RD_DRIVE;
                end
            end
            ST_WR_LOW: begin
                if (collide) begin
                    state_d = ST_COLLIDE;
                    err_d   = 1'b1;
                end else if (wr_s) begin
                    // Data is captured at the rising edge of the write strobe
                    wdata_d = data_s;
                    if (cnt_q >= CNT_MAX) begin
                        state_d = ST_WR_COMMIT;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_COMMIT: begin
                if (collide) begin
                    state_d = ST_COLLIDE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_DRIVE: begin
                if (collide) begin
                    state_d = ST_COLLIDE;
                    err_d   = 1'b1;
                end else if (rd_s || !selected) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLIDE: begin
                if (rd_s && wr_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Bus lamp reset overrides everything, aborting any write in flight
        if (lr_s) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end
        data_out_d = (state_d == ST_RD_DRIVE) ? rd_val : '0;
    end

    // FSM state and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    assign commit = (state_q == ST_WR_COMMIT) && !lr_s && wr_hit;

    // Lamp register file: cleared by either reset, written on commit
    always_ff @(posedge clock) begin
        // NOTE: this storage is reset explicitly because lamps must come up
        // dark; it is small enough that a reset network costs nothing real.
        if (reset || lr_s) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit && addr_q == ADDR_W'(k)) regs_q[k] <= wdata_q;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_lamp
        assign lamp_state[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign data_out        = data_out_q;
    assign data_oe         = (state_q == ST_RD_DRIVE);
    assign reg_write_valid = commit;
    assign reg_write_addr  = addr_q;
    assign reg_write_data  = wdata_q;
    assign strobe_error    = err_q;

endmodule
